digseg_scan: RTL
================

Name: digseg_scan

Overview:
- Parametrised multi-digit seven-segment display controller on the Wishbone-style peripheral bus.
- Holds a hex value per digit plus decimal-point, blink and control registers.
- Drives one shared, time-multiplexed segment bus and a one-hot digit-anode strobe.
- Replaces the fixed two-digit combinational decoder with a bus-readable register file, a registered single-cycle ack, scan timing and per-digit blink.

Parameters:
- NUM_DIGITS, 4, number of digits scanned. Legal range 1..8.
- SCAN_DIV, 50000, clk cycles each digit is lit. Must be >= 2.
- BLINK_FRAMES, 64, full scan frames per blink half-period. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- bus_addr_i  in  32  byte address; only [3:2] are decoded.
- bus_data_i  in  32  write data.
- bus_data_o  out  32  read data, valid while bus_ack_o=1.
- bus_select_i  in  1  access request; held by the master until ack.
- bus_we_i  in  1  1=write, 0=read.
- bus_ack_o  out  1  one-cycle access acknowledge.
- seg_o  out  8  segments, active-low: [6:0]=g,f,e,d,c,b,a; [7]=dp.
- an_o  out  NUM_DIGITS  digit enables, active-low, one-hot.

Behaviour:
- Registers (addr[3:2]):
  - 0 DATA: 4 bits per digit; digit k at [4k+3:4k]; digit 0 is the least significant nibble.
  - 1 CTRL: bit0 enable, bit1 blink_en.
  - 2 DP: bit k lights the dp of digit k.
  - 3 BLINK: bit k makes digit k blink.
  - Bits at or above the implemented width are ignored on write and read back 0.
- Reset (rst=0, asynchronous): DATA=0, CTRL=0x1, DP=0, BLINK=0, bus_ack_o=0, bus_data_o=0, seg_o=8'hFF, an_o=all ones; scan, blink and phase counters all 0.
- Bus handshake:
  - bus_select_i=1 with bus_ack_o=0 -> next cycle bus_ack_o=1 for exactly one cycle.
  - On a write, the register updates on that same edge. On a read, bus_data_o is loaded on that edge.
  - The cycle after an ack, ack is always 0, even if select is still held. Back-to-back accesses therefore complete every 2 cycles.
  - Select deasserted before ack -> no access occurs.
  - bus_data_o is 0 whenever ack=0.
- Scan:
  - A prescaler counts 0..SCAN_DIV-1. On its wrap, the digit index advances 0..NUM_DIGITS-1 and then wraps to 0.
  - A frame is one wrap of the digit index. The blink frame counter counts 0..BLINK_FRAMES-1; on its wrap, blink_phase toggles.
- Outputs:
  - Registered, updated every clock from the current digit index. an_o bit [index]=0, all other bits 1.
  - seg_o[6:0] is the active-low hex decode of the digit nibble, 0-F. Examples: 0->7'h40, 4->7'h19, A->7'h08, F->7'h0E.
  - seg_o[7] = ~DP[index].
  - A register write is visible on seg_o at most 1 cycle after its ack.
- Blanking:
  - If blink_en & BLINK[index] & blink_phase, then seg_o=8'hFF and an_o still strobes.
  - If enable=0, then seg_o=8'hFF and an_o=all ones. Counters keep running so the scan phase stays continuous.
- Boundaries:
  - NUM_DIGITS=1: index is held at 0 and an_o=1'b0.
  - A write during the lit period changes the lit digit on the next cycle; there is no tearing of the scan order.
  - Asynchronous reset mid-access drops ack and discards the access.
- Counter widths use $clog2 of each limit. No counter exceeds its limit.

Test Plan:
- Reset then release, NUM_DIGITS=4, SCAN_DIV=4 -> seg_o=8'hFF and an_o=4'hF during reset. After release: an_o=4'b1110 for 4 cycles, then 1101, 1011, 0111, 1110.
- Write DATA=0x00001234; read it back -> ack exactly 1 cycle after select. Read returns 0x00001234. While an_o=1110, seg_o=8'h99 (digit 4).
- Write DATA=0xFFFFFFFF with NUM_DIGITS=4, then read -> returns 0x0000FFFF. Read of DP (addr 0x8) after writing 0xFF returns 0xF; seg_o[7]=0 on every digit.
- Set CTRL=0x3, BLINK=0x1, BLINK_FRAMES=2 -> digit 0 shows its value for 2 frames, then seg_o=8'hFF during its slot for 2 frames. Digits 1-3 are unaffected.
- Write CTRL=0x0 -> from the next cycle, an_o=4'hF and seg_o=8'hFF. Writing CTRL=0x1 resumes at the digit index the free-running counter has reached.
- Hold select for 5 cycles with we=0 -> ack pattern 0,1,0,1,0. Assert rst=0 in the cycle before an expected ack -> ack stays 0 and all registers return to reset values.

Source files
------------

// File: rtl/digseg_scan.sv
// Multi-digit seven-segment scan controller with a small bus-mapped register file.
// Registers (addr[3:2]): 0 DATA nibbles, 1 CTRL {blink_en, enable}, 2 DP, 3 BLINK.
module digseg_scan #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           bus_addr_i,
   input  logic [31:0]           bus_data_i,
   output logic [31:0]           bus_data_o,
   input  logic                  bus_select_i,
   input  logic                  bus_we_i,
   output logic                  bus_ack_o,
   output logic [7:0]            seg_o,
   output logic [NUM_DIGITS-1:0] an_o
);

   localparam int unsigned DATA_W = 4 * NUM_DIGITS;
   localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [1:0] A_DATA  = 2'd0;
   localparam logic [1:0] A_CTRL  = 2'd1;
   localparam logic [1:0] A_DP    = 2'd2;
   localparam logic [1:0] A_BLINK = 2'd3;

   // register file
   logic [DATA_W-1:0]     data_q,  data_d;
   logic [1:0]            ctrl_q,  ctrl_d;
   logic [NUM_DIGITS-1:0] dp_q,    dp_d;
   logic [NUM_DIGITS-1:0] blink_q, blink_d;

   // bus side
   logic                  ack_q,   ack_d;
   logic [31:0]           rdata_q, rdata_d;

   // scan timing
   logic [PRE_W-1:0]      pre_q,   pre_d;
   logic [IDX_W-1:0]      idx_q,   idx_d;
   logic [FRM_W-1:0]      frm_q,   frm_d;
   logic                  phase_q, phase_d;

   // display outputs
   logic [7:0]            seg_q,   seg_d;
   logic [NUM_DIGITS-1:0] an_q,    an_d;

   logic                  access_c;
   logic                  pre_wrap_c;
   logic                  idx_wrap_c;
   logic                  frm_wrap_c;
   logic [31:0]           rd_val_c;
   logic [3:0]            nib_c;
   logic                  dp_bit_c;
   logic                  blink_bit_c;
   logic                  addr_unused_c;

   assign addr_unused_c = ^{bus_addr_i[31:4], bus_addr_i[1:0]};

   // Active-low hex decode, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   // A new access starts only when the previous ack has dropped
   assign access_c   = bus_select_i & ~ack_q;
   assign pre_wrap_c = (pre_q == PRE_W'(SCAN_DIV - 1));
   assign idx_wrap_c = (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign frm_wrap_c = (frm_q == FRM_W'(BLINK_FRAMES - 1));

   // Read mux; unimplemented bits read back as zero
   always_comb begin
      rd_val_c = '0;
      unique case (bus_addr_i[3:2])
         A_DATA:  rd_val_c = 32'(data_q);
         A_CTRL:  rd_val_c = 32'(ctrl_q);
         A_DP:    rd_val_c = 32'(dp_q);
         A_BLINK: rd_val_c = 32'(blink_q);
      endcase
   end

   // Select the nibble, dp and blink bit of the digit currently being scanned
   always_comb begin
      nib_c       = '0;
      dp_bit_c    = 1'b0;
      blink_bit_c = 1'b0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_c       = data_q[4*k +: 4];
            dp_bit_c    = dp_q[k];
            blink_bit_c = blink_q[k];
         end
      end
   end

   // Next-state logic for bus, registers, counters and display
   always_comb begin
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      dp_d    = dp_q;
      blink_d = blink_q;
      ack_d   = access_c;
      rdata_d = '0;
      pre_d   = pre_q;
      idx_d   = idx_q;
      frm_d   = frm_q;
      phase_d = phase_q;
      seg_d   = 8'hFF;
      an_d    = '1;

      if (access_c && bus_we_i) begin
         unique case (bus_addr_i[3:2])
            A_DATA:  data_d  = DATA_W'(bus_data_i);
            A_CTRL:  ctrl_d  = bus_data_i[1:0];
            A_DP:    dp_d    = NUM_DIGITS'(bus_data_i);
            A_BLINK: blink_d = NUM_DIGITS'(bus_data_i);
         endcase
      end
      if (access_c && !bus_we_i) begin
         rdata_d = rd_val_c;
      end

      // Prescaler -> digit index -> frame counter -> blink phase
      pre_d = pre_wrap_c ? '0 : pre_q + PRE_W'(1);
      if (pre_wrap_c) begin
         idx_d = idx_wrap_c ? '0 : idx_q + IDX_W'(1);
         if (idx_wrap_c) begin
            frm_d = frm_wrap_c ? '0 : frm_q + FRM_W'(1);
            if (frm_wrap_c) begin
               phase_d = ~phase_q;
            end
         end
      end

      // Counters keep running while disabled so the scan phase stays continuous
      if (ctrl_q[0]) begin
         for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
               an_d[k] = 1'b0;
            end
         end
         if (!(ctrl_q[1] && blink_bit_c && phase_q)) begin
            seg_d = {~dp_bit_c, hex7(nib_c)};
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         ctrl_q  <= 2'b01;
         dp_q    <= '0;
         blink_q <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         frm_q   <= '0;
         phase_q <= 1'b0;
         seg_q   <= 8'hFF;
         an_q    <= '1;
      end else begin
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         dp_q    <= dp_d;
         blink_q <= blink_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         frm_q   <= frm_d;
         phase_q <= phase_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign bus_ack_o  = ack_q;
   assign bus_data_o = rdata_q;
   assign seg_o      = seg_q;
   assign an_o       = an_q;

endmodule
